// File: rtl/tt_micro_pkg.sv
// Shared types and defaults for the micro-format tile output schedulers.
// Holds the arbiter state encoding, default sizing and a small index helper.
package tt_micro_pkg;

  localparam int         N_TILES_DEF    = 4;
  localparam int         OWNER_W        = $clog2(N_TILES_DEF);
  localparam logic [7:0] IDLE_VALUE_DEF = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // Next tile index after idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/tt_micro_out_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after rr_ptr,
// searching upward with wrap-around. Usable by any tile scheduler.
module rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr_ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  function automatic logic [W-1:0] offset(input logic [W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s -= N;
    return W'(s);
  endfunction

  // Scanning from the farthest offset down lets the nearest hit win.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[offset(rr_ptr, k)]) begin
        found = 1'b1;
        idx   = offset(rr_ptr, k);
      end
    end
  end

endmodule

// File: rtl/tt_micro_out_arbiter.sv
// Round-robin owner of the shared uo_out pad bank with hold-limit rotation
// and a one-cycle idle gap between successive owners.
module tt_micro_out_arbiter
  import tt_micro_pkg::*;
#(
  parameter int         N_TILES    = N_TILES_DEF,
  parameter int         MAX_HOLD   = 16,
  parameter logic [7:0] IDLE_VALUE = IDLE_VALUE_DEF,
  localparam int        SEL_W      = $clog2(N_TILES),
  localparam int        HOLD_W     = $clog2(MAX_HOLD)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_TILES-1:0]   req,
  input  logic [8*N_TILES-1:0] tile_out,
  output logic [N_TILES-1:0]   grant,
  output logic [SEL_W-1:0]     owner,
  output logic                 busy,
  output logic [7:0]           uo_out
);

  arb_state_e          state_q, state_d;
  logic [N_TILES-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0]    owner_q, owner_d;
  logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic                pick_found;
  logic [SEL_W-1:0]    pick_idx;
  logic                owner_req;
  logic                others_req;
  logic                hold_limit;

  rr_pick #(
    .N (N_TILES),
    .W (SEL_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  assign owner_req  = req[owner_q];
  assign others_req = |(req & ~grant_q);
  assign hold_limit = (hold_q == HOLD_W'(MAX_HOLD - 1));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;

    case (state_q)
      IDLE, GAP: begin
        // GAP arbitrates exactly like IDLE; it just never lasts more than a cycle.
        if (pick_found) begin
          state_d           = GRANT;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          hold_d            = '0;
          rr_ptr_d          = SEL_W'(wrap_inc(int'(pick_idx), N_TILES));
        end else begin
          state_d = IDLE;
          grant_d = '0;
          owner_d = '0;
        end
      end

      GRANT: begin
        if (!owner_req || (hold_limit && others_req)) begin
          state_d = GAP;
          grant_d = '0;
          owner_d = '0;
        end else if (!hold_limit) begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        owner_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
    end
  end

  assign grant = grant_q;
  assign owner = owner_q;
  assign busy  = (state_q == GRANT);

  // Live tile data straight to the pads; select comes only from registers.
  always_comb begin
    uo_out = IDLE_VALUE;
    if (busy) uo_out = tile_out[int'(owner_q)*8 +: 8];
  end

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
  a_busy_grant    : assert property (@(posedge clk) disable iff (!rst_n) busy == (grant_q != '0));

endmodule

// File: tb/tb_tt_micro_out_arbiter.sv
// Bench for tt_micro_out_arbiter: directed scenarios with literal expectations
// plus a cycle-level ownership model compared on every falling edge.
module tb_tt_micro_out_arbiter;
  import tt_micro_pkg::*;

  localparam int N        = 4;
  localparam int MAX_HOLD = 16;
  localparam int BOUND    = (N - 1) * (MAX_HOLD + 1) + 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       req;
  logic [8*N-1:0]     tile_out;
  logic [N-1:0]       grant;
  logic [OWNER_W-1:0] owner;
  logic               busy;
  logic [7:0]         uo_out;

  int checks   = 0;
  int failures = 0;

  tt_micro_out_arbiter #(
    .N_TILES    (N),
    .MAX_HOLD   (MAX_HOLD),
    .IDLE_VALUE (8'h00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .tile_out (tile_out),
    .grant    (grant),
    .owner    (owner),
    .busy     (busy),
    .uo_out   (uo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ownership model: -1 means nobody owns the pads. An unowned cycle always
  // arbitrates at the next edge; dropping ownership forces one unowned cycle.
  int m_owner, m_run, m_ptr, m_t;
  bit m_others, m_hit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_run   = 0;
      m_ptr   = 0;
    end else if (m_owner >= 0) begin
      m_others = 1'b0;
      for (int i = 0; i < N; i++) if (i != m_owner && req[i]) m_others = 1'b1;
      if (!req[m_owner] || (m_run >= MAX_HOLD && m_others)) m_owner = -1;
      else m_run++;
    end else begin
      m_hit = 1'b0;
      for (int k = 0; k < N; k++) begin
        m_t = (m_ptr + k) % N;
        if (!m_hit && req[m_t]) begin
          m_hit   = 1'b1;
          m_owner = m_t;
          m_run   = 1;
          m_ptr   = (m_t + 1) % N;
        end
      end
    end
  end

  // Compare process: model vs DUT plus fairness and gap invariants.
  int             wait_cnt [N];
  logic [N-1:0]   prev_grant;
  logic [N-1:0]   exp_grant;
  logic [7:0]     exp_uo;

  always @(negedge clk) begin
    exp_grant = '0;
    exp_uo    = 8'h00;
    if (m_owner >= 0) begin
      exp_grant[m_owner] = 1'b1;
      exp_uo             = tile_out[8*m_owner +: 8];
    end
    check("sb_grant", 32'(grant), 32'(exp_grant));
    check("sb_owner", 32'(owner), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check("sb_busy", 32'(busy), 32'(m_owner >= 0));
    check("sb_uo_out", 32'(uo_out), 32'(exp_uo));
    check("sb_onehot0", 32'($onehot0(grant)), 32'd1);
    if (prev_grant != '0 && grant != '0) check("sb_no_direct_switch", 32'(grant), 32'(prev_grant));
    prev_grant = rst_n ? grant : '0;
    for (int i = 0; i < N; i++) begin
      if (rst_n && req[i] && !grant[i]) begin
        wait_cnt[i]++;
        check("sb_starvation", 32'(wait_cnt[i] <= BOUND), 32'd1);
      end else begin
        wait_cnt[i] = 0;
      end
    end
  end

  task automatic do_reset(input logic [N-1:0] r);
    @(posedge clk);
    #2 rst_n = 1'b0;
    req = r;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  logic [N-1:0] g_log [35];
  int ok_cnt, c0, c1, cz;

  initial begin
    prev_grant = '0;
    rst_n      = 1'b0;
    req        = 4'b1111;
    tile_out   = 32'hDDCC_BBAA;

    // 1: reset with all requests held, then first owner is tile 0
    repeat (2) @(posedge clk);
    #1;
    check("t1_rst_grant", 32'(grant), 32'h0);
    check("t1_rst_uo", 32'(uo_out), 32'h00);
    check("t1_rst_busy", 32'(busy), 32'h0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("t1_grant", 32'(grant), 32'b0001);
    check("t1_owner", 32'(owner), 32'd0);
    check("t1_uo", 32'(uo_out), 32'hAA);

    // 2: lone requester keeps the grant with no gap
    do_reset(4'b0100);
    ok_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (grant == 4'b0100 && uo_out == tile_out[23:16]) ok_cnt++;
      #1 tile_out = $urandom;
    end
    check("t2_lone_hold_cycles", 32'(ok_cnt), 32'd40);

    // 3: two constant requesters rotate every 16 cycles with a 1-cycle gap
    tile_out = 32'hDDCC_BBAA;
    do_reset(4'b0011);
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      g_log[i] = grant;
    end
    c0 = 0; c1 = 0; cz = 0;
    for (int i = 0; i < 34; i++) begin
      if (g_log[i] == 4'b0001) c0++;
      if (g_log[i] == 4'b0010) c1++;
      if (g_log[i] == 4'b0000) cz++;
    end
    check("t3_tile0_cycles", 32'(c0), 32'd16);
    check("t3_tile1_cycles", 32'(c1), 32'd16);
    check("t3_gap_cycles", 32'(cz), 32'd2);
    check("t3_first_gap", 32'(g_log[16]), 32'b0000);
    check("t3_tile1_start", 32'(g_log[17]), 32'b0010);
    check("t3_second_gap", 32'(g_log[33]), 32'b0000);
    check("t3_period_wrap", 32'(g_log[34]), 32'b0001);

    // 4: owner tile 1 drops; rr_ptr=2 search lands on tile 3
    do_reset(4'b0010);
    ok_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (grant == 4'b0010) ok_cnt++;
    end
    check("t4_tile1_owned", 32'(ok_cnt), 32'd5);
    #1 req = 4'b1001;
    @(posedge clk); #1;
    check("t4_gap_grant", 32'(grant), 32'b0000);
    check("t4_gap_uo", 32'(uo_out), 32'h00);
    @(posedge clk); #1;
    check("t4_grant", 32'(grant), 32'b1000);
    check("t4_owner", 32'(owner), 32'd3);
    check("t4_uo", 32'(uo_out), 32'hDD);

    // 5: asynchronous reset between edges while tile 0 owns the bus
    do_reset(4'b0011);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_async_grant", 32'(grant), 32'h0);
    check("t5_async_busy", 32'(busy), 32'h0);
    check("t5_async_uo", 32'(uo_out), 32'h00);
    req = 4'b0010;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5_after_release", 32'(grant), 32'b0010);

    // 6: slowly toggling random requests, checked by the model and invariants
    do_reset(4'b0000);
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      tile_out = $urandom;
    end

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
